// File: rtl/ledger_validator_p.sv
// Ledger validator: checks sender->receiver transfers against an on-chip account
// table of {id, balance} entries. Missing accounts are created with INIT_BAL on
// a successful transfer. Ready/valid on both sides, one transaction in flight.
// Optional build macro LEDGER_STATS_EN adds wrapping stat_ok / stat_rej counters.
module ledger_validator_p #(
  parameter int unsigned ID_W     = 48,
  parameter int unsigned AMT_W    = 22,
  parameter int unsigned BAL_W    = 24,
  parameter int unsigned DEPTH    = 16384,
  parameter int unsigned INIT_BAL = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [ID_W-1:0]  in_sender,
  input  logic [ID_W-1:0]  in_receiver,
  input  logic [AMT_W-1:0] in_amount,
  input  logic             in_block_start,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ID_W-1:0]  out_sender,
  output logic [ID_W-1:0]  out_receiver,
  output logic [AMT_W-1:0] out_amount,
  output logic [1:0]       out_status
`ifdef LEDGER_STATS_EN
  ,
  output logic [31:0]      stat_ok,
  output logic [31:0]      stat_rej
`endif
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One spare bit so count can reach DEPTH and count + 2 never wraps.
  localparam int unsigned CW = $clog2(DEPTH + 1) + 1;
  localparam int unsigned EW = ID_W + BAL_W;

  localparam logic [BAL_W-1:0] InitBal = BAL_W'(INIT_BAL);
  localparam logic [CW-1:0]    DepthC  = CW'(DEPTH);

  localparam logic [1:0] StatusOk   = 2'd0;
  localparam logic [1:0] StatusFund = 2'd1;
  localparam logic [1:0] StatusFull = 2'd2;

  typedef enum logic [2:0] {
    StIdle,
    StScan,
    StDecide,
    StWrS,
    StWrR,
    StResp
  } state_e;

  state_e state_q;

  // Latched transaction and table bookkeeping
  logic [CW-1:0]    count_q;
  logic [ID_W-1:0]  snd_q;
  logic [ID_W-1:0]  rcv_q;
  logic [AMT_W-1:0] amt_q;

  // Scan pipeline: rd_addr_q is the address being issued, cmp_idx_q is the
  // entry whose data sits in rd_data_q this cycle.
  logic [AW-1:0]    rd_addr_q;
  logic             cmp_valid_q;
  logic [CW-1:0]    cmp_idx_q;
  logic [EW-1:0]    rd_data_q;

  logic             s_found_q;
  logic             r_found_q;
  logic [AW-1:0]    s_ptr_q;
  logic [AW-1:0]    r_ptr_q;
  logic [BAL_W-1:0] s_bal_q;
  logic [BAL_W-1:0] r_bal_q;
  logic [BAL_W-1:0] s_new_q;
  logic [BAL_W-1:0] r_new_q;

  logic [EW-1:0]    mem [DEPTH];

  // Write port, driven only from the two write states
  logic             we;
  logic [AW-1:0]    waddr;
  logic [EW-1:0]    wdata;

  // Scan compare
  logic [ID_W-1:0]  rd_id;
  logic [BAL_W-1:0] rd_bal;
  logic             s_hit;
  logic             r_hit;
  logic             last_cmp;
  logic             scan_done;

  // Decision
  logic             self_xfer;
  logic             need_s;
  logic             need_r;
  logic [CW-1:0]    need;
  logic [CW-1:0]    free_slots;
  logic [BAL_W-1:0] amt_ext;
  logic [BAL_W-1:0] s_bal_eff;
  logic [BAL_W-1:0] r_bal_eff;
  logic [BAL_W:0]   r_sum;
  logic [BAL_W-1:0] r_sat;
  logic [AW-1:0]    s_ptr_eff;
  logic [AW-1:0]    r_ptr_eff;
  logic [1:0]       dec_status;

  logic             accept;

  assign in_ready = (state_q == StIdle) && rst_n;
  assign accept   = in_valid && in_ready;

  // Account table: one write port, registered read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rd_data_q <= mem[rd_addr_q];
  end

  // Write port mux for the sender and receiver write-back states
  always_comb begin
    we    = 1'b0;
    waddr = s_ptr_q;
    wdata = {snd_q, s_new_q};
    if (state_q == StWrS) begin
      we = 1'b1;
    end else if (state_q == StWrR) begin
      we    = 1'b1;
      waddr = r_ptr_q;
      wdata = {rcv_q, r_new_q};
    end
  end

  // Compare the entry returned by the RAM against both ids
  always_comb begin
    rd_id     = rd_data_q[EW-1:BAL_W];
    rd_bal    = rd_data_q[BAL_W-1:0];
    s_hit     = cmp_valid_q && !s_found_q && (rd_id == snd_q);
    r_hit     = cmp_valid_q && !r_found_q && (rd_id == rcv_q);
    last_cmp  = cmp_valid_q && (cmp_idx_q == (count_q - CW'(1)));
    scan_done = ((s_found_q || s_hit) && (r_found_q || r_hit)) || last_cmp;
  end

  // Funds / capacity decision and the new balances
  always_comb begin
    self_xfer  = (snd_q == rcv_q);
    need_s     = !s_found_q;
    need_r     = !self_xfer && !r_found_q;
    need       = CW'(need_s) + CW'(need_r);
    free_slots = DepthC - count_q;
    amt_ext    = BAL_W'(amt_q);
    s_bal_eff  = s_found_q ? s_bal_q : InitBal;
    r_bal_eff  = self_xfer ? s_bal_eff : (r_found_q ? r_bal_q : InitBal);
    r_sum      = {1'b0, r_bal_eff} + {1'b0, amt_ext};
    r_sat      = r_sum[BAL_W] ? {BAL_W{1'b1}} : r_sum[BAL_W-1:0];
    // New sender takes slot count, a new receiver the slot after it.
    s_ptr_eff  = s_found_q ? s_ptr_q : AW'(count_q);
    r_ptr_eff  = r_found_q ? r_ptr_q : AW'(count_q + CW'(need_s));
    if (need > free_slots) begin
      dec_status = StatusFull;
    end else if (s_bal_eff < amt_ext) begin
      dec_status = StatusFund;
    end else begin
      dec_status = StatusOk;
    end
  end

  // Main controller: accept, scan, decide, write back, respond
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      count_q      <= '0;
      rd_addr_q    <= '0;
      cmp_valid_q  <= 1'b0;
      out_valid    <= 1'b0;
      out_status   <= StatusOk;
      out_sender   <= '0;
      out_receiver <= '0;
      out_amount   <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            snd_q       <= in_sender;
            rcv_q       <= in_receiver;
            amt_q       <= in_amount;
            s_found_q   <= 1'b0;
            r_found_q   <= 1'b0;
            rd_addr_q   <= '0;
            cmp_valid_q <= 1'b0;
            cmp_idx_q   <= '0;
            if (in_block_start) begin
              count_q <= '0;
            end
            // An empty table needs no scan at all.
            if (in_block_start || (count_q == '0)) begin
              state_q <= StDecide;
            end else begin
              state_q <= StScan;
            end
          end
        end

        StScan: begin
          rd_addr_q   <= rd_addr_q + AW'(1);
          cmp_valid_q <= 1'b1;
          cmp_idx_q   <= CW'(rd_addr_q);
          if (s_hit) begin
            s_found_q <= 1'b1;
            s_ptr_q   <= AW'(cmp_idx_q);
            s_bal_q   <= rd_bal;
          end
          if (r_hit) begin
            r_found_q <= 1'b1;
            r_ptr_q   <= AW'(cmp_idx_q);
            r_bal_q   <= rd_bal;
          end
          if (scan_done) begin
            cmp_valid_q <= 1'b0;
            state_q     <= StDecide;
          end
        end

        StDecide: begin
          out_sender   <= snd_q;
          out_receiver <= rcv_q;
          out_amount   <= amt_q;
          out_status   <= dec_status;
          s_ptr_q      <= s_ptr_eff;
          r_ptr_q      <= r_ptr_eff;
          // Self-transfer leaves the balance as it was.
          s_new_q      <= self_xfer ? s_bal_eff : (s_bal_eff - amt_ext);
          r_new_q      <= r_sat;
          if (dec_status == StatusOk) begin
            count_q <= count_q + need;
            state_q <= StWrS;
          end else begin
            out_valid <= 1'b1;
            state_q   <= StResp;
          end
        end

        StWrS: begin
          if (self_xfer) begin
            out_valid <= 1'b1;
            state_q   <= StResp;
          end else begin
            state_q <= StWrR;
          end
        end

        StWrR: begin
          out_valid <= 1'b1;
          state_q   <= StResp;
        end

        StResp: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef LEDGER_STATS_EN
  // Result counters, cleared with the table on a block start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_ok  <= '0;
      stat_rej <= '0;
    end else if (accept && in_block_start) begin
      stat_ok  <= '0;
      stat_rej <= '0;
    end else if (out_valid && out_ready) begin
      if (out_status == StatusOk) begin
        stat_ok <= stat_ok + 32'd1;
      end else if ((out_status == StatusFund) || (out_status == StatusFull)) begin
        stat_rej <= stat_rej + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ledger_validator_p.sv
// Scoreboard bench for ledger_validator_p (small table so capacity limits are reachable).
module tb_ledger_validator_p;

  localparam int unsigned ID_W     = 48;
  localparam int unsigned AMT_W    = 22;
  localparam int unsigned BAL_W    = 24;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned INIT_BAL = 100;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [ID_W-1:0]  in_sender = '0;
  logic [ID_W-1:0]  in_receiver = '0;
  logic [AMT_W-1:0] in_amount = '0;
  logic             in_block_start = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ID_W-1:0]  out_sender;
  logic [ID_W-1:0]  out_receiver;
  logic [AMT_W-1:0] out_amount;
  logic [1:0]       out_status;
`ifdef LEDGER_STATS_EN
  logic [31:0]      stat_ok;
  logic [31:0]      stat_rej;
`endif

  always #5 clk = ~clk;

  ledger_validator_p #(
    .ID_W    (ID_W),
    .AMT_W   (AMT_W),
    .BAL_W   (BAL_W),
    .DEPTH   (DEPTH),
    .INIT_BAL(INIT_BAL)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_sender     (in_sender),
    .in_receiver   (in_receiver),
    .in_amount     (in_amount),
    .in_block_start(in_block_start),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_sender    (out_sender),
    .out_receiver  (out_receiver),
    .out_amount    (out_amount),
    .out_status    (out_status)
`ifdef LEDGER_STATS_EN
    ,
    .stat_ok       (stat_ok),
    .stat_rej      (stat_rej)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [ID_W-1:0]  s;
    logic [ID_W-1:0]  r;
    logic [AMT_W-1:0] a;
    logic [1:0]       st;
    int               lat;
  } exp_t;

  exp_t exp_q[$];

  // Reference ledger: balances by id, plus ids in allocation order
  longint unsigned  bal_m [logic [ID_W-1:0]];
  logic [ID_W-1:0]  ids_m [$];

  // Expected status and accept-to-out_valid cycle count for one transaction
  task automatic model_accept(input logic [ID_W-1:0] s, input logic [ID_W-1:0] r,
                              input logic [AMT_W-1:0] a, input logic bs);
    exp_t e;
    int cnt, ps, pr, need, dec, last;
    bit sf, rf, slf;
    longint unsigned sb, rb, sum, maxb;
    if (bs) begin
      bal_m.delete();
      ids_m.delete();
    end
    maxb = (64'd1 << BAL_W) - 1;
    cnt = ids_m.size();
    sf  = bal_m.exists(s);
    rf  = bal_m.exists(r);
    slf = (s == r);
    ps  = -1;
    pr  = -1;
    for (int i = 0; i < cnt; i++) begin
      if (ids_m[i] == s) ps = i;
      if (ids_m[i] == r) pr = i;
    end
    need = (sf ? 0 : 1) + ((slf || rf) ? 0 : 1);
    if (need > int'(DEPTH) - cnt) begin
      e.st = 2'd2;
    end else begin
      sb = sf ? bal_m[s] : longint'(INIT_BAL);
      if (sb < longint'(a)) begin
        e.st = 2'd1;
      end else begin
        e.st = 2'd0;
        rb = slf ? sb : (rf ? bal_m[r] : longint'(INIT_BAL));
        if (!sf) ids_m.push_back(s);
        if (!slf && !rf) ids_m.push_back(r);
        if (slf) begin
          bal_m[s] = sb;
        end else begin
          bal_m[s] = sb - longint'(a);
          sum = rb + longint'(a);
          bal_m[r] = (sum > maxb) ? maxb : sum;
        end
      end
    end
    if (cnt == 0) begin
      dec = 1;
    end else begin
      if (sf && (slf || rf)) last = (ps > pr) ? ps : pr;
      else last = cnt - 1;
      dec = last + 3;
    end
    e.lat = dec + ((e.st != 2'd0) ? 1 : (slf ? 2 : 3));
    e.s = s;
    e.r = r;
    e.a = a;
    exp_q.push_back(e);
  endtask

  task automatic drive_txn(input logic [ID_W-1:0] s, input logic [ID_W-1:0] r,
                           input logic [AMT_W-1:0] a, input logic bs);
    int w;
    w = 0;
    @(negedge clk);
    in_valid       = 1'b1;
    in_sender      = s;
    in_receiver    = r;
    in_amount      = a;
    in_block_start = bs;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      $display("FAIL accept_timeout: got in_ready 0 expected 1");
      $fatal(1, "no accept");
    end
    @(posedge clk);
    model_accept(s, r, a, bs);
    #1;
    in_valid       = 1'b0;
    in_block_start = 1'b0;
  endtask

  task automatic recv_txn(input int hold);
    exp_t e;
    int lat;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check_eq("out_valid", 64'(out_valid), 64'd1);
    check_eq("latency", 64'(lat), 64'(e.lat));
    check_eq("status", 64'(out_status), 64'(e.st));
    check_eq("sender", 64'(out_sender), 64'(e.s));
    check_eq("receiver", 64'(out_receiver), 64'(e.r));
    check_eq("amount", 64'(out_amount), 64'(e.a));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("stall_valid", 64'(out_valid), 64'd1);
      check_eq("stall_in_ready", 64'(in_ready), 64'd0);
      check_eq("stall_status", 64'(out_status), 64'(e.st));
      check_eq("stall_sender", 64'(out_sender), 64'(e.s));
      check_eq("stall_amount", 64'(out_amount), 64'(e.a));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("idle_in_ready", 64'(in_ready), 64'd1);
    check_eq("valid_dropped", 64'(out_valid), 64'd0);
  endtask

  task automatic txn(input logic [ID_W-1:0] s, input logic [ID_W-1:0] r,
                     input logic [AMT_W-1:0] a, input logic bs);
    drive_txn(s, r, a, bs);
    recv_txn(0);
  endtask

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_status", 64'(out_status), 64'd0);
    check_eq("rst_sender", 64'(out_sender), 64'd0);
    check_eq("rst_receiver", 64'(out_receiver), 64'd0);
    check_eq("rst_amount", 64'(out_amount), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Basic transfer, then insufficient funds
    txn(48'd1, 48'd2, 22'd30, 1'b1);
    txn(48'd1, 48'd2, 22'd80, 1'b0);
    txn(48'd1, 48'd2, 22'd71, 1'b0);
    // Fill the table, then a fifth id is rejected
    txn(48'd3, 48'd4, 22'd10, 1'b0);
    txn(48'd5, 48'd1, 22'd5, 1'b0);
    txn(48'd1, 48'd2, 22'd70, 1'b0);
    txn(48'd2, 48'd5, 22'd1, 1'b0);
    txn(48'd2, 48'd4, 22'd200, 1'b0);

    // Self-transfers on a fresh block
    txn(48'd7, 48'd7, 22'd50, 1'b1);
    txn(48'd7, 48'd7, 22'd100, 1'b0);
    txn(48'd7, 48'd7, 22'd101, 1'b0);

    // Output back-pressure
    drive_txn(48'd8, 48'd9, 22'd20, 1'b0);
    recv_txn(10);

    // Reset while scanning drops the transaction and empties the table
    drive_txn(48'd7, 48'd8, 22'd1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_eq("midrst_out_valid", 64'(out_valid), 64'd0);
    check_eq("midrst_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("midrst_idle", 64'(in_ready), 64'd1);
    void'(exp_q.pop_front());
    bal_m.delete();
    ids_m.delete();
    txn(48'd9, 48'd10, 22'd5, 1'b0);
    txn(48'd9, 48'd10, 22'd96, 1'b0);

    // Mixed traffic over a small id pool
    for (int i = 0; i < 30; i++) begin
      txn(48'($urandom_range(1, 6)), 48'($urandom_range(1, 6)),
          22'($urandom_range(0, 120)), ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
